// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two combinational read ports,
// one synchronous write port, an optional hardwired zero register, optional
// write-to-read bypass and a per-register busy scoreboard.
//
// Strobe semantics: wr_en and rsv_en are single-cycle strobes sampled on the
// rising clk edge; there is no ready/backpressure, so every strobe seen at an
// edge is acted on. Writeback clears busy, issue sets it, and when both hit the
// same register on the same edge the reservation wins (a new producer is
// pending).
module regfile_sb #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_conflict
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              rsv_conflict_q, rsv_conflict_d;

    logic wr_ok, rsv_ok;

    // True when addr names the hardwired zero register and that feature is on.
    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_EN != 0) && (addr == ZERO_IDX);
    endfunction

    // Next-state: apply the write, then the reservation so it wins on a tie,
    // and flag a conflict only when an older producer is still outstanding.
    always_comb begin
        mem_d          = mem_q;
        busy_d         = busy_q;
        wr_ok          = wr_en && !is_zero(wr_addr);
        rsv_ok         = rsv_en && !is_zero(rsv_addr);
        rsv_conflict_d = 1'b0;
        if (wr_ok) begin
            mem_d[wr_addr]  = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
            rsv_conflict_d   = busy_q[rsv_addr] && !(wr_ok && (wr_addr == rsv_addr));
        end
    end

    // State registers; reset clears storage, scoreboard and the conflict pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q         <= '0;
            rsv_conflict_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            busy_q         <= busy_d;
            rsv_conflict_q <= rsv_conflict_d;
        end
    end

    // Read port A: zero register first, then same-cycle forwarding, then storage.
    always_comb begin
        rd_data_a = mem_q[rd_addr_a];
        busy_a    = busy_q[rd_addr_a];
        if (is_zero(rd_addr_a)) begin
            rd_data_a = '0;
            busy_a    = 1'b0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            busy_a    = 1'b0;
        end
    end

    // Read port B: identical priority to port A, fully independent.
    always_comb begin
        rd_data_b = mem_q[rd_addr_b];
        busy_b    = busy_q[rd_addr_b];
        if (is_zero(rd_addr_b)) begin
            rd_data_b = '0;
            busy_b    = 1'b0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            busy_b    = 1'b0;
        end
    end

    assign rsv_conflict = rsv_conflict_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb: one bypassing instance and one
// non-bypassing instance driven by the same stimulus.
module tb_regfile_sb;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
    logic              wr_en, rsv_en;
    logic [ADDR_W-1:0] wr_addr, rsv_addr;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] rd_data_a, rd_data_b;
    logic              busy_a, busy_b, rsv_conflict;
    logic [DATA_W-1:0] nb_rd_data_a, nb_rd_data_b;
    logic              nb_busy_a, nb_busy_b, nb_rsv_conflict;

    int n_cmp;
    int n_err;

    logic [DATA_W-1:0] exp_q[$];

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_EN(1), .ZERO_REG(31), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_conflict(rsv_conflict)
    );

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_EN(1), .ZERO_REG(31), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(nb_rd_data_a), .rd_data_b(nb_rd_data_b),
        .busy_a(nb_busy_a), .busy_b(nb_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_conflict(nb_rsv_conflict)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_strobes();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        cycle();
        idle_strobes();
        #1;
    endtask

    task automatic do_reserve(input logic [ADDR_W-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
        cycle();
        idle_strobes();
        #1;
    endtask

    // Directed write vectors for the queue-checked readback
    logic [ADDR_W-1:0] vec_addr [4];
    logic [DATA_W-1:0] vec_data [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        vec_addr[0] = 5'd10; vec_data[0] = 64'hDEAD_BEEF_0000_0001;
        vec_addr[1] = 5'd11; vec_data[1] = 64'h0123_4567_89AB_CDEF;
        vec_addr[2] = 5'd0;  vec_data[2] = 64'hFFFF_FFFF_FFFF_FFFE;
        vec_addr[3] = 5'd30; vec_data[3] = 64'h8000_0000_0000_0000;

        // Reset
        rst_n = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_addr_a = 5'd27;
        rd_addr_b = 5'd31;
        #1;
        check("reset_rd_a", rd_data_a, 64'd0);
        check("reset_rd_b", rd_data_b, 64'd0);
        check("reset_busy_a", busy_a, 1'b0);
        check("reset_busy_b", busy_b, 1'b0);
        check("reset_conflict", rsv_conflict, 1'b0);

        // Basic write/read
        do_write(5'd27, 64'd256);
        rd_addr_b = 5'd27;
        #1;
        check("basic_rd_b", rd_data_b, 64'd256);
        check("basic_nb_rd_b", nb_rd_data_b, 64'd256);
        rd_addr_a = 5'd31;
        #1;
        check("basic_rd_a_zero", rd_data_a, 64'd0);

        // Zero register: write and reserve both discarded
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 5'd31;
        #1;
        check("zero_rd_pre", rd_data_a, 64'd0);
        check("zero_busy_pre", busy_a, 1'b0);
        cycle();
        #1;
        check("zero_rd_post", rd_data_a, 64'd0);
        check("zero_busy_post", busy_a, 1'b0);
        check("zero_conflict", rsv_conflict, 1'b0);
        idle_strobes();
        do_reserve(5'd31);
        check("zero_conflict_2", rsv_conflict, 1'b0);
        check("zero_nb_rd", nb_rd_data_a, 64'd0);

        // Bypass vs no-bypass
        do_write(5'd5, 64'd7);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'd9;
        rd_addr_a = 5'd5;
        #1;
        check("bypass_pre", rd_data_a, 64'd9);
        check("nobypass_pre", nb_rd_data_a, 64'd7);
        cycle();
        idle_strobes();
        #1;
        check("bypass_post", rd_data_a, 64'd9);
        check("nobypass_post", nb_rd_data_a, 64'd9);

        // Scoreboard life cycle on reg 3
        rd_addr_a = 5'd3;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        #1;
        check("sb_busy_before_edge", busy_a, 1'b0);
        cycle();
        idle_strobes();
        #1;
        check("sb_busy_set", busy_a, 1'b1);
        check("sb_no_conflict", rsv_conflict, 1'b0);
        do_reserve(5'd3);
        check("sb_conflict_pulse", rsv_conflict, 1'b1);
        check("sb_busy_kept", busy_a, 1'b1);
        check("sb_nb_conflict", nb_rsv_conflict, 1'b1);
        cycle();
        check("sb_conflict_cleared", rsv_conflict, 1'b0);
        check("sb_busy_still", busy_a, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd42;
        #1;
        check("sb_busy_bypassed", busy_a, 1'b0);
        check("sb_nb_busy_pre", nb_busy_a, 1'b1);
        check("sb_rd_bypassed", rd_data_a, 64'd42);
        cycle();
        idle_strobes();
        #1;
        check("sb_busy_cleared", busy_a, 1'b0);
        check("sb_nb_busy_cleared", nb_busy_a, 1'b0);
        check("sb_rd_42", rd_data_a, 64'd42);

        // Plain writes read back through the expected queue, on both ports
        for (int i = 0; i < 4; i++) begin
            do_write(vec_addr[i], vec_data[i]);
            exp_q.push_back(vec_data[i]);
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = vec_addr[i];
            rd_addr_b = vec_addr[i];
            #1;
            check("vec_rd_a", rd_data_a, exp_q[0]);
            check("vec_rd_b", rd_data_b, exp_q.pop_front());
        end

        // Same-edge write + reserve on busy reg 8
        rd_addr_b = 5'd8;
        do_reserve(5'd8);
        check("same_busy_before", busy_b, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 64'h1234_5678_9ABC_DEF0;
        rsv_en = 1'b1; rsv_addr = 5'd8;
        cycle();
        idle_strobes();
        #1;
        check("same_rd", rd_data_b, 64'h1234_5678_9ABC_DEF0);
        check("same_busy", busy_b, 1'b1);
        check("same_conflict", rsv_conflict, 1'b0);

        // Arm a conflict pulse, then reset asynchronously mid-cycle
        do_reserve(5'd8);
        check("pre_reset_conflict", rsv_conflict, 1'b1);
        rd_addr_a = 5'd27;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rd_a", rd_data_a, 64'd0);
        check("async_rd_b", rd_data_b, 64'd0);
        check("async_busy_b", busy_b, 1'b0);
        check("async_conflict", rsv_conflict, 1'b0);
        wr_en = 1'b1; wr_addr = 5'd27; wr_data = 64'd5;
        rsv_en = 1'b1; rsv_addr = 5'd8;
        cycle();
        idle_strobes();
        rst_n = 1'b1;
        #1;
        check("reset_write_lost", rd_data_a, 64'd0);
        check("reset_rsv_lost", busy_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the datapath register file: DATA_W x 2^ADDR_W storage, two combinational read ports, one synchronous write port.
- Adds a hardwired zero register, an optional write-to-read bypass and an integrated per-register busy scoreboard.
- The scoreboard lets the issue stage stall on operands whose producing write has not yet come back.
- Sits between decode/issue (read and reserve) and writeback (write and clear busy).

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, address width; depth = 2^ADDR_W.
- ZERO_EN, 1, when 1, register ZERO_REG always reads 0 and is never busy.
- ZERO_REG, 31, index of the hardwired zero register.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_a  output  DATA_W  read port A data (combinational).
- rd_data_b  output  DATA_W  read port B data (combinational).
- busy_a  output  1  register at rd_addr_a has a pending write (combinational).
- busy_b  output  1  register at rd_addr_b has a pending write (combinational).
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rsv_en  input  1  reserve strobe: marks rsv_addr busy.
- rsv_addr  input  ADDR_W  register to reserve.
- rsv_conflict  output  1  registered one-cycle pulse: a reservation hit an already-busy register.

Behaviour:
- Reset, while rst_n=0, asynchronous:
  - all storage = 0; busy vector = 0; rsv_conflict = 0.
  - read outputs therefore show 0; busy_a/busy_b show 0.
- Write:
  - on a rising clk edge with wr_en=1, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - Writes to ZERO_REG are discarded when ZERO_EN=1.
  - A write to a non-busy register is legal and raises no error.
- Read, combinational, zero added latency:
  - rd_data_x = 0 if ZERO_EN and rd_addr_x==ZERO_REG.
  - Otherwise, if BYPASS and wr_en and wr_addr==rd_addr_x, rd_data_x = wr_data.
  - Otherwise rd_data_x = mem[rd_addr_x].
  - With BYPASS=0, written data is visible the cycle after the edge.
- Busy flags:
  - busy_x = busy[rd_addr_x].
  - Forced to 0 for the zero register.
  - Forced to 0 when BYPASS and wr_en and wr_addr==rd_addr_x, because the operand is supplied this cycle.
- Reserve:
  - on a rising edge with rsv_en=1 and rsv_addr not the zero register, busy[rsv_addr] <= 1.
  - A reservation of the zero register is ignored and never flags a conflict.
- Simultaneous write and reserve, same address, same edge: the reserve wins.
  - Data is written and busy ends at 1, because a new producer is pending.
  - No conflict is flagged, since the write clears the old producer.
- Conflict detection:
  - rsv_conflict <= rsv_en and busy[rsv_addr] was 1 before the edge and no clearing write to the same address occurs that edge.
  - Otherwise rsv_conflict <= 0. This gives a one-cycle pulse.
  - busy stays 1; it is a single bit, not a count.
- Reads of the same address on both ports are independent and identical.
- Reset asserted mid-operation:
  - an in-flight write or reserve on that edge is lost.
  - All state clears immediately, with no wait for clk.
- X-free: every output is defined from reset release onward.

Test Plan:
- Reset then read: rst_n=0→1, rd_addr_a=27, rd_addr_b=31 → rd_data_a=0, rd_data_b=0, busy_a=busy_b=0, rsv_conflict=0.
- Basic write/read: wr_en=1, wr_addr=27, wr_data=256, one edge, wr_en=0; rd_addr_b=27 → rd_data_b=256. Then rd_addr_a=31 → 0.
- Zero register: wr_en=1, wr_addr=31, wr_data=64'hFFFF_FFFF_FFFF_FFFF; rsv_en=1, rsv_addr=31 → rd_data of 31 stays 0, busy stays 0, rsv_conflict stays 0.
- Bypass: mem[5]=7; in the same cycle drive wr_en=1, wr_addr=5, wr_data=9 with rd_addr_a=5 → rd_data_a=9 before the edge (BYPASS=1). Rerun with BYPASS=0 → 7 before the edge, 9 after.
- Scoreboard life cycle:
  - rsv_en on reg 3 → busy_a=1 from the next cycle.
  - A second reserve of 3 → rsv_conflict=1 for exactly one cycle; busy stays 1.
  - wr_en to 3 with data 42 → busy clears to 0 and reads return 42.
- Same-edge write+reserve on reg 8 (busy=1 beforehand) → mem[8]=new data, busy[8]=1, rsv_conflict=0. Then assert rst_n=0 mid-cycle → all reads and busy flags go 0 asynchronously.
